id_ex_stage_reg: RTL and testbench

- Pipeline register between the instruction-decode stage (control unit plus register file) and the execute stage.
- Captures decoded control signals, operands and fields each cycle.
- Detects load-use hazards and inserts bubbles on hazard or branch flush.
- Honours a global freeze from the memory stage.

---
 rtl/id_ex_stage_reg.sv | 156 +++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/freeze handling and bubble insertion.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_val_rn,
   input  logic [DATA_W-1:0] id_val_rm,
   input  logic              id_imm,
   input  logic [11:0]       id_shift_operand,
   input  logic [23:0]       id_signed_imm24,
   input  logic [REG_W-1:0]  id_dest,
   input  logic [REG_W-1:0]  id_src1,
   input  logic [REG_W-1:0]  id_src2,
   input  logic              id_two_src,
   input  logic [3:0]        id_alu_command,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_wb_en,
   input  logic              id_branch,
   input  logic              id_status_en,
   input  logic              id_carry,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_val_rn,
   output logic [DATA_W-1:0] ex_val_rm,
   output logic              ex_imm,
   output logic [11:0]       ex_shift_operand,
   output logic [23:0]       ex_signed_imm24,
   output logic [REG_W-1:0]  ex_dest,
   output logic [REG_W-1:0]  ex_src1,
   output logic [REG_W-1:0]  ex_src2,
   output logic              ex_two_src,
   output logic [3:0]        ex_alu_command,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_wb_en,
   output logic              ex_branch,
   output logic              ex_status_en,
   output logic              ex_carry,
   output logic              hazard,
   output logic              ex_branch_taken,
   output logic [15:0]       bubble_count
);

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] val_rn;
      logic [DATA_W-1:0] val_rm;
      logic              imm;
      logic [11:0]       shift_operand;
      logic [23:0]       signed_imm24;
      logic [REG_W-1:0]  dest;
      logic [REG_W-1:0]  src1;
      logic [REG_W-1:0]  src2;
      logic              two_src;
      logic [3:0]        alu_command;
      logic              mem_read;
      logic              mem_write;
      logic              wb_en;
      logic              branch;
      logic              status_en;
      logic              carry;
   } stage_t;

   stage_t stage_q, stage_d;
   logic   insert_bubble;

   // Load in EX whose result is needed by the instruction now in ID.
   assign hazard = stage_q.valid && stage_q.mem_read && stage_q.wb_en && id_valid &&
                   ((id_src1 == stage_q.dest) || (id_two_src && (id_src2 == stage_q.dest)));

   assign insert_bubble = flush || hazard;

   always_comb begin
      stage_d = stage_q;
      if (freeze) begin
         stage_d = stage_q;
      end else if (insert_bubble) begin
         stage_d = '0;
      end else begin
         stage_d.valid         = id_valid;
         stage_d.pc            = id_pc;
         stage_d.val_rn        = id_val_rn;
         stage_d.val_rm        = id_val_rm;
         stage_d.imm           = id_imm;
         stage_d.shift_operand = id_shift_operand;
         stage_d.signed_imm24  = id_signed_imm24;
         stage_d.dest          = id_dest;
         stage_d.src1          = id_src1;
         stage_d.src2          = id_src2;
         stage_d.two_src       = id_two_src;
         stage_d.alu_command   = id_alu_command;
         stage_d.carry         = id_carry;
         // An empty slot must never cause a side effect downstream.
         stage_d.mem_read      = id_valid && id_mem_read;
         stage_d.mem_write     = id_valid && id_mem_write;
         stage_d.wb_en         = id_valid && id_wb_en;
         stage_d.branch        = id_valid && id_branch;
         stage_d.status_en     = id_valid && id_status_en;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign ex_valid         = stage_q.valid;
   assign ex_pc            = stage_q.pc;
   assign ex_val_rn        = stage_q.val_rn;
   assign ex_val_rm        = stage_q.val_rm;
   assign ex_imm           = stage_q.imm;
   assign ex_shift_operand = stage_q.shift_operand;
   assign ex_signed_imm24  = stage_q.signed_imm24;
   assign ex_dest          = stage_q.dest;
   assign ex_src1          = stage_q.src1;
   assign ex_src2          = stage_q.src2;
   assign ex_two_src       = stage_q.two_src;
   assign ex_alu_command   = stage_q.alu_command;
   assign ex_mem_read      = stage_q.mem_read;
   assign ex_mem_write     = stage_q.mem_write;
   assign ex_wb_en         = stage_q.wb_en;
   assign ex_branch        = stage_q.branch;
   assign ex_status_en     = stage_q.status_en;
   assign ex_carry         = stage_q.carry;
   assign ex_branch_taken  = stage_q.branch && stage_q.valid;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [15:0] bubble_count_q;

   // Counts only flush/hazard bubbles, saturating at all ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bubble_count_q <= '0;
      end else if (!freeze && insert_bubble && (bubble_count_q != 16'hFFFF)) begin
         bubble_count_q <= bubble_count_q + 16'd1;
      end
   end

   assign bubble_count = bubble_count_q;
`else
   assign bubble_count = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: reset, table-driven hazard/flush/freeze vectors,
// asynchronous mid-pipeline reset and (with ID_EX_BUBBLE_CNT_EN) counter saturation.
module tb_id_ex_stage_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze, flush, id_valid, id_imm, id_two_src;
   logic [31:0] id_pc, id_val_rn, id_val_rm;
   logic [11:0] id_shift_operand;
   logic [23:0] id_signed_imm24;
   logic [3:0]  id_dest, id_src1, id_src2, id_alu_command;
   logic        id_mem_read, id_mem_write, id_wb_en, id_branch, id_status_en, id_carry;
   logic        ex_valid, ex_imm, ex_two_src;
   logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
   logic [11:0] ex_shift_operand;
   logic [23:0] ex_signed_imm24;
   logic [3:0]  ex_dest, ex_src1, ex_src2, ex_alu_command;
   logic        ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_status_en, ex_carry;
   logic        hazard, ex_branch_taken;
   logic [15:0] bubble_count;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_cnt = 16'h0;

   always #5 clk = ~clk;

   id_ex_stage_reg dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
      .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
      .id_shift_operand(id_shift_operand), .id_signed_imm24(id_signed_imm24),
      .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
      .id_alu_command(id_alu_command), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_wb_en(id_wb_en), .id_branch(id_branch),
      .id_status_en(id_status_en), .id_carry(id_carry),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm),
      .ex_imm(ex_imm), .ex_shift_operand(ex_shift_operand),
      .ex_signed_imm24(ex_signed_imm24), .ex_dest(ex_dest), .ex_src1(ex_src1),
      .ex_src2(ex_src2), .ex_two_src(ex_two_src), .ex_alu_command(ex_alu_command),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en),
      .ex_branch(ex_branch), .ex_status_en(ex_status_en), .ex_carry(ex_carry),
      .hazard(hazard), .ex_branch_taken(ex_branch_taken), .bubble_count(bubble_count)
   );

   logic ex_any;
   assign ex_any = |{ex_valid, ex_pc, ex_val_rn, ex_val_rm, ex_imm, ex_shift_operand,
                     ex_signed_imm24, ex_dest, ex_src1, ex_src2, ex_two_src, ex_alu_command,
                     ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_status_en, ex_carry,
                     ex_branch_taken};

   typedef struct {
      logic       valid;
      logic [3:0] src1, src2;
      logic       two;
      logic [3:0] dest, alu;
      logic       mr, mw, wb, br, fl, fz;
      logic       hz;
      logic       ev;
      logic [3:0] edest, ealu;
      logic       emr, emw, ewb, etk;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] cnt_exp();
`ifdef ID_EX_BUBBLE_CNT_EN
      return exp_cnt;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic idle_inputs();
      freeze = 0; flush = 0; id_valid = 0; id_pc = 0; id_val_rn = 0; id_val_rm = 0;
      id_imm = 0; id_shift_operand = 0; id_signed_imm24 = 0; id_dest = 0; id_src1 = 0;
      id_src2 = 0; id_two_src = 0; id_alu_command = 0; id_mem_read = 0; id_mem_write = 0;
      id_wb_en = 0; id_branch = 0; id_status_en = 0; id_carry = 0;
   endtask

   task automatic apply(input vec_t v);
      id_valid = v.valid; id_src1 = v.src1; id_src2 = v.src2; id_two_src = v.two;
      id_dest = v.dest; id_alu_command = v.alu; id_mem_read = v.mr; id_mem_write = v.mw;
      id_wb_en = v.wb; id_branch = v.br; flush = v.fl; freeze = v.fz;
   endtask

   initial begin
      // Order: valid src1 src2 two dest alu mr mw wb br flush freeze | hz | ev edest ealu emr emw ewb etk
      vecs[0]  = '{1, 1, 2, 1, 3, 2, 0, 0, 1, 0, 0, 0, 0, 1, 3, 2, 0, 0, 1, 0};
      vecs[1]  = '{1, 3, 0, 0, 5, 4, 1, 0, 1, 0, 0, 0, 0, 1, 5, 4, 1, 0, 1, 0};
      vecs[2]  = '{1, 5, 1, 1, 6, 2, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
      vecs[3]  = '{1, 5, 1, 1, 6, 2, 0, 0, 1, 0, 0, 0, 0, 1, 6, 2, 0, 0, 1, 0};
      vecs[4]  = '{1, 0, 0, 0, 7, 4, 1, 0, 1, 0, 0, 0, 0, 1, 7, 4, 1, 0, 1, 0};
      vecs[5]  = '{1, 1, 7, 0, 8, 4, 0, 1, 0, 0, 0, 0, 0, 1, 8, 4, 0, 1, 0, 0};
      vecs[6]  = '{1, 0, 0, 0, 7, 4, 1, 0, 1, 0, 0, 0, 0, 1, 7, 4, 1, 0, 1, 0};
      vecs[7]  = '{1, 1, 7, 1, 9, 2, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
      vecs[8]  = '{0, 7, 7, 1, 10, 0, 1, 1, 1, 1, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0};
      vecs[9]  = '{1, 0, 0, 0, 11, 2, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[10] = '{1, 0, 0, 0, 12, 4, 1, 0, 1, 0, 0, 0, 0, 1, 12, 4, 1, 0, 1, 0};
      vecs[11] = '{1, 12, 0, 0, 13, 2, 0, 0, 1, 0, 1, 1, 1, 1, 12, 4, 1, 0, 1, 0};
      vecs[12] = '{1, 12, 0, 0, 13, 2, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
      vecs[13] = '{1, 0, 0, 0, 14, 4, 1, 0, 0, 0, 0, 0, 0, 1, 14, 4, 1, 0, 0, 0};
      vecs[14] = '{1, 14, 0, 0, 15, 2, 0, 0, 1, 0, 0, 0, 0, 1, 15, 2, 0, 0, 1, 0};
      vecs[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
      vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1};

      // Reset with random inputs toggling underneath.
      rst = 0;
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         {freeze, flush, id_valid, id_mem_read, id_wb_en, id_mem_write} = 6'($urandom);
         id_pc = $urandom; id_val_rn = $urandom; id_dest = 4'($urandom);
         id_src1 = 4'($urandom); id_alu_command = 4'($urandom);
      end
      @(negedge clk);
      chk("reset_ex_zero", 128'(ex_any), 128'(0));
      chk("reset_hazard", 128'(hazard), 128'(0));
      chk("reset_count", 128'(bubble_count), 128'(0));
      idle_inputs();
      rst = 1;

      // First instruction after reset, with all data fields distinct.
      @(negedge clk);
      id_valid = 1; id_alu_command = 4'b0010; id_wb_en = 1; id_dest = 3;
      id_pc = 32'h0000_1234; id_val_rn = 32'hDEAD_BEEF; id_val_rm = 32'h0BAD_F00D;
      id_imm = 1; id_shift_operand = 12'hABC; id_signed_imm24 = 24'h123456;
      id_src1 = 1; id_src2 = 2; id_two_src = 1; id_carry = 1; id_status_en = 1;
      @(posedge clk); #1;
      chk("add_ctrl", 128'({ex_valid, ex_alu_command, ex_wb_en, ex_dest, ex_mem_read}),
          128'({1'b1, 4'b0010, 1'b1, 4'd3, 1'b0}));
      chk("add_data", 128'({ex_pc, ex_val_rn, ex_val_rm, ex_imm, ex_shift_operand}),
          128'({32'h0000_1234, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 12'hABC}));
      chk("add_fields", 128'({ex_signed_imm24, ex_carry, ex_status_en, ex_src1, ex_src2,
                              ex_two_src}),
          128'({24'h123456, 1'b1, 1'b1, 4'd1, 4'd2, 1'b1}));
      @(negedge clk);
      idle_inputs();

      for (int i = 0; i < 17; i++) begin
         vec_t v;
         v = vecs[i];
         @(negedge clk);
         apply(v);
         #1;
         chk($sformatf("hazard_row%0d", i), 128'(hazard), 128'(v.hz));
         if (!v.fz && (v.fl || v.hz) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         @(posedge clk); #1;
         chk($sformatf("ex_row%0d", i),
             128'({ex_valid, ex_dest, ex_alu_command, ex_mem_read, ex_mem_write, ex_wb_en,
                   ex_branch_taken}),
             128'({v.ev, v.edest, v.ealu, v.emr, v.emw, v.ewb, v.etk}));
         chk($sformatf("count_row%0d", i), 128'(bubble_count), 128'(cnt_exp()));
      end

      // Asynchronous reset between edges while a store sits in EX.
      @(negedge clk);
      idle_inputs();
      id_valid = 1; id_mem_write = 1; id_dest = 2;
      @(posedge clk); #1;
      chk("store_loaded", 128'(ex_mem_write), 128'(1));
      @(negedge clk);
      rst = 0;
      #1;
      chk("async_rst_mw", 128'(ex_mem_write), 128'(0));
      chk("async_rst_all", 128'(ex_any), 128'(0));
      chk("async_rst_cnt", 128'(bubble_count), 128'(0));
      @(negedge clk);
      idle_inputs();
      rst = 1;

`ifdef ID_EX_BUBBLE_CNT_EN
      @(negedge clk);
      flush = 1;
      repeat (65535) @(posedge clk);
      #1;
      chk("count_reach_max", 128'(bubble_count), 128'(16'hFFFF));
      repeat (2) @(posedge clk);
      #1;
      chk("count_saturate", 128'(bubble_count), 128'(16'hFFFF));
      flush = 0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
